signed_multiply: RTL and testbench
==================================

Name: signed_multiply

Overview:
Pipelined two's-complement multiplier built as a registered partial-product adder tree. Accepts one operand pair per clock, tagged by a valid bit. Produces the full-width signed product a fixed number of cycles later with a matching valid. Used as a generic arithmetic leaf in datapaths that need a parameterised, timing-friendly multiply.

Parameters:
A_WIDTH, 3, width of signed operand in_A (>=1)
B_WIDTH, 6, width of signed operand in_B (>=1)
Derived localparams: S = min(A_WIDTH,B_WIDTH); L = clog2(S); P = A_WIDTH+B_WIDTH; LATENCY = L+1

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid this cycle
in_A  in  A_WIDTH  signed multiplicand/multiplier
in_B  in  B_WIDTH  signed multiplicand/multiplier
out_valid  out  1  out_C holds a new product this cycle
out_C  out  P  signed product in_A*in_B

Behaviour:
- Reset (reset=0, async): all pipeline registers, out_C = 0, out_valid = 0.
- Operand roles: narrower operand is the multiplier M (in_A when A_WIDTH<=B_WIDTH, else in_B); other is the multiplicand N, sign-extended to P bits.
- Partial products pp[j], j=0..S-1: (M[j] ? N_ext : 0) << j, P bits. pp[S-1] is negated (two's-complement weight of M's sign bit): pp[S-1] = -(M[S-1] ? N_ext : 0) << (S-1).
- Tree: middle_layers[0][0..S-1] registers the pp set on the clock after input. Layer k (1..L-1) entry i = layer k-1 entries 2i + 2i+1 (missing odd entry treated as 0; unused entries forced to 0). Final stage adds the remaining <=2 entries of layer L-1 into out_C register.
- S=1 (L=0): single stage, out_C <= registered product directly.
- All adds modulo 2^P; exact for all inputs (no overflow possible at width P).
- Latency: out_valid asserted exactly LATENCY cycles after the in_valid cycle (defaults: 3). Valid bit travels a LATENCY-deep shift register aligned with data.
- Throughput: one pair per cycle, no stall, no backpressure; back-to-back inputs yield back-to-back outputs in order.
- Data registers in middle stages advance every cycle regardless of valid. out_C loads only when the final-stage valid is 1; otherwise holds its last value. out_valid is a one-cycle pulse per accepted input.
- Reset mid-operation: in-flight results discarded; no out_valid pulses after reset for inputs sampled before reset deassertion.

Decomposition:
- Shared package: none required; width helpers (min, clog2-derived localparams) stay local.
- One natural sub-module: mult_tree_adder_stage (one registered layer of pairwise P-bit adds with valid passthrough), instantiated L times via generate; top builds pp and the output register.

Test Plan:
- Defaults, reset low 2 cycles then high, in_valid=1, in_A=3, in_B=-30 -> out_valid high 3 cycles later, out_C = -90 (9'h1A6).
- Extremes: in_A=-4,in_B=-32 -> 128; in_A=-4,in_B=31 -> -124; in_A=3,in_B=31 -> 93; in_A=0,in_B=-32 -> 0.
- Streaming: valid every cycle with 4 distinct pairs -> 4 consecutive out_valid cycles, results in order; a gap in in_valid -> matching gap in out_valid, out_C held.
- Exhaustive: all 8x64 combos at defaults vs reference product; then A_WIDTH=6,B_WIDTH=3 (roles swapped) and A_WIDTH=B_WIDTH=1 (latency 1; -1*-1 = 1).
- Reset mid-flight: drive valid input, assert reset before result emerges -> out_C=0, out_valid=0 immediately and no later pulse.
- Idle: in_valid=0 with changing operands -> out_valid stays 0, out_C unchanged.

Source files
------------

// File: rtl/mult_tree_adder_stage.sv
// One registered layer of the partial-product adder tree.
//
// Entry i of the output is in_data[2i] + in_data[2i+1] (a missing odd partner counts as
// zero). Entries past the first ceil(N/2) are forced to zero, so the array width stays N
// across every layer and only the low entries carry live sums. The valid bit moves with
// the data.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_valid  valid bit aligned with in_data
//   in_data   N entries of P-bit partial sums
//   out_valid registered in_valid
//   out_data  N entries of P-bit registered pairwise sums
module mult_tree_adder_stage #(
  parameter int P             = 9,
  parameter int N             = 3,
  parameter bit LOAD_ON_VALID = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [N-1:0][P-1:0]   in_data,
  output logic                  out_valid,
  output logic [N-1:0][P-1:0]   out_data
);

  localparam int HALF = (N + 1) / 2;

  // Zero padding gives every entry a partner without out-of-range indexing.
  logic [2*N-1:0][P-1:0] padded;
  logic [N-1:0][P-1:0]   sum_d;

  assign padded = {{(N * P){1'b0}}, in_data};

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      if (i < HALF) begin
        sum_d[i] = padded[2*i] + padded[2*i+1];
      end
    end
  end

  // The last layer holds its value between valid results; inner layers run freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (!LOAD_ON_VALID || in_valid) begin
        out_data <= sum_d;
      end
    end
  end

endmodule

// File: rtl/signed_multiply.sv
// Pipelined two's-complement multiplier built from a registered partial-product adder tree.
//
// The narrower operand is the multiplier M, the other is the multiplicand N, sign-extended
// to P bits. One partial product per multiplier bit is registered, then reduced pairwise
// over clog2(S) registered layers. Latency is clog2(S)+1 cycles, one pair per clock.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   operand pair valid this cycle
//   in_A       signed operand, A_WIDTH bits
//   in_B       signed operand, B_WIDTH bits
//   out_valid  one-cycle pulse: out_C holds a new product
//   out_C      signed product, A_WIDTH+B_WIDTH bits, held between results
module signed_multiply #(
  parameter int A_WIDTH = 3,
  parameter int B_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         in_A,
  input  logic [B_WIDTH-1:0]         in_B,
  output logic                       out_valid,
  output logic [A_WIDTH+B_WIDTH-1:0] out_C
);

  localparam int S = (A_WIDTH <= B_WIDTH) ? A_WIDTH : B_WIDTH;
  localparam int L = $clog2(S);
  localparam int P = A_WIDTH + B_WIDTH;

  logic [S-1:0]        mult;
  logic [P-1:0]        mcand_ext;
  logic [S-1:0][P-1:0] pp;

  if (A_WIDTH <= B_WIDTH) begin : g_mult_a
    assign mult      = in_A;
    assign mcand_ext = {{(P - B_WIDTH){in_B[B_WIDTH-1]}}, in_B};
  end else begin : g_mult_b
    assign mult      = in_B;
    assign mcand_ext = {{(P - A_WIDTH){in_A[A_WIDTH-1]}}, in_A};
  end

  // The multiplier's sign bit carries weight -2^(S-1), hence the negated top term.
  always_comb begin
    pp = '0;
    for (int j = 0; j < S; j++) begin
      if (mult[j]) begin
        pp[j] = mcand_ext << j;
      end
    end
    pp[S-1] = -pp[S-1];
  end

  if (L == 0) begin : g_single
    // One-bit multiplier: the lone partial product is the whole result.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_C     <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_C <= pp[0];
        end
      end
    end
  end else begin : g_tree
    logic [S-1:0][P-1:0] layer_data  [L+1];
    logic                layer_valid [L+1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        layer_data[0]  <= '0;
        layer_valid[0] <= 1'b0;
      end else begin
        layer_data[0]  <= pp;
        layer_valid[0] <= in_valid;
      end
    end

    for (genvar k = 1; k <= L; k++) begin : g_layer
      mult_tree_adder_stage #(
        .P             (P),
        .N             (S),
        .LOAD_ON_VALID (k == L)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (layer_valid[k-1]),
        .in_data   (layer_data[k-1]),
        .out_valid (layer_valid[k]),
        .out_data  (layer_data[k])
      );
    end

    assign out_C     = layer_data[L][0];
    assign out_valid = layer_valid[L];
  end

endmodule

// File: tb/tb_signed_multiply.sv
// Bench for signed_multiply: three instances (3x6 default, 6x3 swapped roles, 1x1) driven
// in lockstep and checked every cycle against a product-history model.
module tb_signed_multiply;

  localparam int HIST = 4096;

  logic clk;
  logic reset;

  logic       v0, v1, v2;
  logic [2:0] a0;
  logic [5:0] b0;
  logic [5:0] a1;
  logic [2:0] b1;
  logic [0:0] a2, b2;

  logic       ov0, ov1, ov2;
  logic [8:0] c0, c1;
  logic [1:0] c2;

  signed_multiply #(.A_WIDTH(3), .B_WIDTH(6)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_A(a0), .in_B(b0),
    .out_valid(ov0), .out_C(c0)
  );
  signed_multiply #(.A_WIDTH(6), .B_WIDTH(3)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_A(a1), .in_B(b1),
    .out_valid(ov1), .out_C(c1)
  );
  signed_multiply #(.A_WIDTH(1), .B_WIDTH(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_A(a2), .in_B(b2),
    .out_valid(ov2), .out_C(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Model: what each instance accepted at each clock edge, and its true product.
  bit hist_v [3][HIST];
  int hist_p [3][HIST];
  int held   [3];
  int flush_mark = 0;
  int lat    [3] = '{3, 3, 1};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int got_c(input int d);
    case (d)
      0:       return int'($signed(c0));
      1:       return int'($signed(c1));
      default: return int'($signed(c2));
    endcase
  endfunction

  function automatic int got_v(input int d);
    case (d)
      0:       return int'(ov0);
      1:       return int'(ov1);
      default: return int'(ov2);
    endcase
  endfunction

  // Called at the negedge following edge edge_n.
  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      int idx;
      int ev;
      idx = edge_n - lat[d] + 1;
      ev  = 0;
      if (!reset) begin
        held[d] = 0;
      end else if (idx >= flush_mark && idx >= 0 && idx < HIST && hist_v[d][idx]) begin
        ev      = 1;
        held[d] = hist_p[d][idx];
      end
      check_eq($sformatf("dut%0d_valid", d), got_v(d), ev);
      check_eq($sformatf("dut%0d_product", d), got_c(d), held[d]);
    end
  endtask

  task automatic record();
    int e;
    e = edge_n + 1;
    if (e < HIST) begin
      hist_v[0][e] = reset && v0;
      hist_v[1][e] = reset && v1;
      hist_v[2][e] = reset && v2;
      hist_p[0][e] = int'($signed(a0)) * int'($signed(b0));
      hist_p[1][e] = int'($signed(a1)) * int'($signed(b1));
      hist_p[2][e] = int'($signed(a2)) * int'($signed(b2));
    end
  endtask

  // One clock: check outputs, then present the next inputs to all instances.
  task automatic drive(input bit vv, input int idx);
    @(negedge clk);
    check_all();
    v0 = vv; v1 = vv; v2 = vv;
    a0 = idx[2:0];
    b0 = idx[8:3];
    a1 = idx[8:3];
    b1 = idx[2:0];
    a2 = idx[0:0];
    b2 = idx[1:1];
    record();
  endtask

  function automatic int pair(input int a, input int b);
    int av;
    int bv;
    av = a & 7;
    bv = b & 63;
    return av | (bv << 3);
  endfunction

  task automatic assert_reset();
    @(negedge clk);
    check_all();
    reset      = 1'b0;
    flush_mark = edge_n + 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("dut%0d_rst_valid", d), got_v(d), 0);
      check_eq($sformatf("dut%0d_rst_product", d), got_c(d), 0);
      held[d] = 0;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    check_all();
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    record();
  endtask

  int directed [10] = '{3, -30, -4, -32, -4, 31, 3, 31, 0, -32};

  initial begin
    reset = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    held = '{0, 0, 0};

    // Reset held for two cycles, then released.
    @(negedge clk); check_all();
    @(negedge clk); check_all();
    release_reset();

    // Single directed product, then idle until it emerges.
    drive(1'b1, pair(3, -30));
    for (int i = 0; i < 4; i++) drive(1'b0, pair(3, -30));
    check_eq("directed_3x-30", int'($signed(c0)), -90);

    // Extremes streamed back-to-back, then a gap, then more.
    for (int i = 0; i < 5; i++) drive(1'b1, pair(directed[2*i], directed[2*i+1]));
    drive(1'b0, 0);
    drive(1'b0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, pair(i + 1, 7 * i - 20));
    for (int i = 0; i < 5; i++) drive(1'b0, 0);

    // Exhaustive sweep, every cycle valid.
    for (int i = 0; i < 512; i++) drive(1'b1, i);
    for (int i = 0; i < 5; i++) drive(1'b0, 0);

    // Random operands with random valid gaps.
    for (int i = 0; i < 300; i++) drive(1'(($urandom & 3) != 0), int'($urandom_range(0, 511)));

    // Idle with changing operands: no pulses, outputs held.
    for (int i = 0; i < 12; i++) drive(1'b0, int'($urandom_range(0, 511)));

    // Reset while results are in flight.
    drive(1'b1, pair(-4, -32));
    drive(1'b1, pair(3, 31));
    assert_reset();
    @(negedge clk); check_all();
    release_reset();
    for (int i = 0; i < 6; i++) drive(1'b0, int'($urandom_range(0, 511)));

    // Traffic again after reset.
    for (int i = 0; i < 40; i++) drive(1'(($urandom & 1) != 0), int'($urandom_range(0, 511)));
    for (int i = 0; i < 5; i++) drive(1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
